// File: rtl/fusion_pkg.sv
// Shared fusion-core constants, slice/tensor types and the splitter state encoding.
package fusion_pkg;

    localparam int unsigned FEATURE_W    = 512;
    localparam int unsigned NUM_FEATURES = 3;
    localparam int unsigned TENSOR_W     = FEATURE_W * NUM_FEATURES;

    typedef logic [FEATURE_W-1:0] feature_t;
    typedef logic [TENSOR_W-1:0]  tensor_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } splitter_state_e;

endpackage

// File: rtl/tensor_splitter.sv
// Splits one raw tensor into NUM_FEATURES feature slices, LSB slice first, one per handshake.
// Optional SPLITTER_PARITY_EN adds out_parity (even parity of the presented slice).
module tensor_splitter #(
    parameter int unsigned FEATURE_W    = fusion_pkg::FEATURE_W,
    parameter int unsigned NUM_FEATURES = fusion_pkg::NUM_FEATURES,
    localparam int unsigned TENSOR_W    = FEATURE_W * NUM_FEATURES,
    localparam int unsigned IDX_W       = $clog2(NUM_FEATURES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [TENSOR_W-1:0]  in_tensor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FEATURE_W-1:0] out_feature,
    output logic [IDX_W-1:0]     out_index,
    output logic                 out_last,
    output logic                 busy
`ifdef SPLITTER_PARITY_EN
    ,
    output logic                 out_parity
`endif
);

    import fusion_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

    splitter_state_e     state_q, state_d;
    logic [TENSOR_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                is_last;
    logic                accept;
    logic                capture;

    assign is_last = (idx_q == LAST_IDX);
    assign accept  = out_valid & out_ready;
    assign capture = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

    // A new tensor may be captured in the same cycle the last slice leaves, so no bubble.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        if (capture) begin
            state_d = SEND;
            shreg_d = in_tensor;
            idx_d   = '0;
        end else if (accept) begin
            if (is_last) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                shreg_d = shreg_q >> FEATURE_W;
                idx_d   = idx_q + IDX_W'(1);
            end
        end
    end

    always_comb begin
        out_valid   = (state_q == SEND);
        busy        = (state_q == SEND);
        out_index   = idx_q;
        out_last    = out_valid & is_last;
        out_feature = out_valid ? shreg_q[FEATURE_W-1:0] : '0;
        in_ready    = rst_n & ((state_q == IDLE) | (out_last & out_ready));
    end

`ifdef SPLITTER_PARITY_EN
    assign out_parity = ^out_feature;
`endif

endmodule

// File: tb/tb_tensor_splitter.sv
// Directed self-checking bench for tensor_splitter (default 512 x 3 configuration).
module tb_tensor_splitter;

    localparam int unsigned FW = 512;
    localparam int unsigned NF = 3;
    localparam int unsigned TW = FW * NF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] in_tensor;
    logic          out_valid;
    logic          out_ready;
    logic [FW-1:0] out_feature;
    logic [1:0]    out_index;
    logic          out_last;
    logic          busy;
`ifdef SPLITTER_PARITY_EN
    logic          out_parity;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [FW-1:0] f1, f2, f3, f4, f5, f6, fa, fb, fc;
    logic [FW-1:0] exp_f [6];
    logic [1:0]    exp_i [6];

    always #5 clk = ~clk;

    tensor_splitter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_tensor   (in_tensor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_feature (out_feature),
        .out_index   (out_index),
        .out_last    (out_last),
        .busy        (busy)
`ifdef SPLITTER_PARITY_EN
        ,
        .out_parity  (out_parity)
`endif
    );

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkf(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        f1 = {128{4'h1}}; f2 = {128{4'h2}}; f3 = {128{4'h3}};
        f4 = {128{4'h4}}; f5 = {128{4'h5}}; f6 = {128{4'h6}};
        fa = {128{4'ha}}; fb = {128{4'hb}}; fc = {128{4'hc}};

        // reset held for two cycles
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_tensor = '0;
        step();
        step();
        chkb("rst_out_valid", out_valid, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_in_ready", in_ready, 1'b0);
        chkb("rst_out_last", out_last, 1'b0);
        chki("rst_out_index", out_index, 2'd0);
        chkf("rst_out_feature", out_feature, '0);
        rst_n = 1'b1;
        #1;
        chkb("idle_in_ready", in_ready, 1'b1);

        // basic split with continuous out_ready
        in_tensor = {f3, f2, f1}; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chkb("b_valid0", out_valid, 1'b1);
        chkf("b_feat0", out_feature, f1);
        chki("b_idx0", out_index, 2'd0);
        chkb("b_last0", out_last, 1'b0);
        chkb("b_inrdy0", in_ready, 1'b0);
        chkb("b_busy0", busy, 1'b1);
        step();
        chkf("b_feat1", out_feature, f2);
        chki("b_idx1", out_index, 2'd1);
        chkb("b_last1", out_last, 1'b0);
        step();
        chkf("b_feat2", out_feature, f3);
        chki("b_idx2", out_index, 2'd2);
        chkb("b_last2", out_last, 1'b1);
        chkb("b_inrdy2", in_ready, 1'b1);
        step();
        chkb("b_done_valid", out_valid, 1'b0);
        chkb("b_done_busy", busy, 1'b0);

        // backpressure on the middle slice
        in_tensor = {f6, f5, f4}; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chkf("bp_feat0", out_feature, f4);
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chkb("bp_valid_hold", out_valid, 1'b1);
            chkf("bp_feat_hold", out_feature, f5);
            chki("bp_idx_hold", out_index, 2'd1);
            chkb("bp_inrdy_hold", in_ready, 1'b0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chkf("bp_feat1_rel", out_feature, f5);
        step();
        chkf("bp_feat2", out_feature, f6);
        chki("bp_idx2", out_index, 2'd2);
        chkb("bp_last2", out_last, 1'b1);
        step();
        chkb("bp_done_valid", out_valid, 1'b0);

        // back-to-back tensors, no bubble
        exp_f[0] = f1; exp_f[1] = f2; exp_f[2] = f3;
        exp_f[3] = fa; exp_f[4] = fb; exp_f[5] = fc;
        exp_i[0] = 2'd0; exp_i[1] = 2'd1; exp_i[2] = 2'd2;
        exp_i[3] = 2'd0; exp_i[4] = 2'd1; exp_i[5] = 2'd2;
        in_tensor = {f3, f2, f1}; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_tensor = {fc, fb, fa};
        for (int i = 0; i < 6; i++) begin
            if (i == 3) in_valid = 1'b0;
            chkb("b2b_valid", out_valid, 1'b1);
            chkf("b2b_feat", out_feature, exp_f[i]);
            chki("b2b_idx", out_index, exp_i[i]);
            chkb("b2b_last", out_last, (i == 2 || i == 5));
            chkb("b2b_inrdy", in_ready, (i == 2 || i == 5));
            step();
        end
        chkb("b2b_done_valid", out_valid, 1'b0);

        // reset after the first slice is accepted
        in_tensor = {f3, f2, f1}; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chkf("mr_feat1", out_feature, f2);
        rst_n = 1'b0;
        step();
        chkb("mr_valid", out_valid, 1'b0);
        chkb("mr_busy", busy, 1'b0);
        chki("mr_idx", out_index, 2'd0);
        rst_n = 1'b1;
        step();
        chkb("mr_still_idle", out_valid, 1'b0);
        in_tensor = {fc, fb, fa}; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chkf("mr_new_feat0", out_feature, fa);
        chki("mr_new_idx0", out_index, 2'd0);
        step();
        step();
        step();
        chkb("mr_new_done", out_valid, 1'b0);

`ifdef SPLITTER_PARITY_EN
        chkb("par_idle", out_parity, 1'b0);
        in_tensor = {512'h3, 512'h2, 512'h1}; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chkb("par_slice1", out_parity, 1'b1);
        step();
        chkb("par_slice2", out_parity, 1'b1);
        step();
        chkb("par_slice3", out_parity, 1'b0);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
